// File: rtl/flit_mux2.sv
// Registered 2:1 flit multiplexer with a one-hot port select and fixed port-0 priority.
// Optional macro MUX_SEL_ERR_EN adds a registered osel_err flag for illegal select patterns.
module flit_mux2 #(
    parameter int DATA_W = 64,
    parameter int VCH_W  = 2,
    parameter int SEL_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] idata_0,
    input  logic              ivalid_0,
    input  logic [VCH_W-1:0]  ivch_0,
    input  logic [DATA_W-1:0] idata_1,
    input  logic              ivalid_1,
    input  logic [VCH_W-1:0]  ivch_1,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic [VCH_W-1:0]  ovch
`ifdef MUX_SEL_ERR_EN
    ,
    output logic              osel_err
`endif
);

    logic [DATA_W-1:0] data_d;
    logic              valid_d;
    logic [VCH_W-1:0]  vch_d;

    // Explicit if/else (not an AND-OR mux) so an X on the unselected port never reaches the flops.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        data_d  = '0;
        valid_d = 1'b0;
        vch_d   = '0;
        if (sel[0]) begin
            data_d  = idata_0;
            valid_d = ivalid_0;
            vch_d   = ivch_0;
        end else if (sel[1]) begin
            data_d  = idata_1;
            valid_d = ivalid_1;
            vch_d   = ivch_1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            odata  <= '0;
            ovalid <= 1'b0;
            ovch   <= '0;
        end else begin
            odata  <= data_d;
            ovalid <= valid_d;
            ovch   <= vch_d;
        end
    end

`ifdef MUX_SEL_ERR_EN
    logic sel_err_d;

    always_comb begin
        sel_err_d = sel[0] & sel[1];
        for (int i = 2; i < SEL_W; i++) begin
            sel_err_d = sel_err_d | sel[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            osel_err <= 1'b0;
        end else begin
            osel_err <= sel_err_d;
        end
    end
`else
    // Upper select bits carry no routing meaning when the error flag is compiled out.
    logic unused_sel_hi;
    assign unused_sel_hi = ^sel;
`endif

endmodule

// File: tb/tb_flit_mux2.sv
// Self-checking bench for flit_mux2: directed steps plus randomized traffic
// checked against a behavioural model built from the selection rules.
module tb_flit_mux2;

    localparam int DATA_W = 64;
    localparam int VCH_W  = 2;
    localparam int SEL_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              valid;
        logic [VCH_W-1:0]  vch;
    } flit_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] idata_0, idata_1;
    logic              ivalid_0, ivalid_1;
    logic [VCH_W-1:0]  ivch_0, ivch_1;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] odata;
    logic              ovalid;
    logic [VCH_W-1:0]  ovch;
`ifdef MUX_SEL_ERR_EN
    logic              osel_err;
`endif

    int checks = 0;
    int errors = 0;

    flit_mux2 #(.DATA_W(DATA_W), .VCH_W(VCH_W), .SEL_W(SEL_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .idata_0  (idata_0),
        .ivalid_0 (ivalid_0),
        .ivch_0   (ivch_0),
        .idata_1  (idata_1),
        .ivalid_1 (ivalid_1),
        .ivch_1   (ivch_1),
        .sel      (sel),
        .odata    (odata),
        .ovalid   (ovalid),
        .ovch     (ovch)
`ifdef MUX_SEL_ERR_EN
        ,
        .osel_err (osel_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: pick the lowest set bit among sel[1:0] as the source port; nothing selected
    // or reset means an all-zero flit. Illegal select = both low bits or any high bit set.
    task automatic tick(input string tag);
        flit_t port_in [2];
        flit_t exp_f;
        int    src;
        logic  exp_err;
        port_in[0] = '{data: idata_0, valid: ivalid_0, vch: ivch_0};
        port_in[1] = '{data: idata_1, valid: ivalid_1, vch: ivch_1};
        src = -1;
        for (int p = 1; p >= 0; p--) if (sel[p] === 1'b1) src = p;
        exp_f = (rst || src < 0) ? '0 : port_in[src];
        exp_err = !rst && ((sel[1:0] == 2'b11) || (sel >> 2) != 0);
        @(posedge clk);
        #1;
        check({tag, ".odata"}, odata, exp_f.data);
        check({tag, ".ovalid"}, DATA_W'(ovalid), DATA_W'(exp_f.valid));
        check({tag, ".ovch"}, DATA_W'(ovch), DATA_W'(exp_f.vch));
`ifdef MUX_SEL_ERR_EN
        check({tag, ".osel_err"}, DATA_W'(osel_err), DATA_W'(exp_err));
`else
        if (exp_err) begin end
`endif
    endtask

    function automatic logic [DATA_W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [12:0] thermo(input int k);
        int n;
        n = (k % 6) * 3;
        if (n > 13) n = 13;
        return ~(13'h1FFF >> n);
    endfunction

    initial begin
        // Reset with nonzero inputs for two cycles
        rst = 1'b1; sel = 5'b00001;
        idata_0 = 64'hDEAD_BEEF_0123_4567; ivalid_0 = 1'b1; ivch_0 = 2'd3;
        idata_1 = 64'hFEED_FACE_89AB_CDEF; ivalid_1 = 1'b1; ivch_1 = 2'd2;
        tick("reset0");
        tick("reset1");
        rst = 1'b0;
        tick("first_after_reset");

        // Port 1 stream: 10 packets of head + 20 data + tail, then 7 idle cycles
        sel = 5'b00010;
        for (int pkt = 0; pkt < 10; pkt++) begin
            for (int f = 0; f < 22; f++) begin
                idata_0 = rnd64(); ivalid_0 = 1'b1; ivch_0 = 2'($urandom);
                idata_1 = rnd64(); ivalid_1 = 1'b1; ivch_1 = 2'd2;
                if (f > 0 && f < 21) idata_1[12:0] = thermo(pkt * 20 + f - 1);
                tick("p1_flit");
            end
            for (int g = 0; g < 7; g++) begin
                idata_0 = rnd64(); ivalid_0 = 1'b1;
                idata_1 = rnd64(); ivalid_1 = 1'b0;
                tick("p1_gap");
            end
        end

        // Port 0 directed
        sel = 5'b00001; idata_0 = 64'h9; ivalid_0 = 1'b1; ivch_0 = 2'd1;
        tick("p0_select");
        check("p0_data_literal", odata, 64'h0000_0000_0000_0009);

        // Priority with both select bits
        sel = 5'b00011; idata_0 = 64'hAAAA_0000_AAAA_0000; idata_1 = 64'h5555_1111_5555_1111;
        ivalid_0 = 1'b1; ivalid_1 = 1'b1; ivch_0 = 2'd0; ivch_1 = 2'd3;
        tick("priority");
        sel = 5'b00001;
        tick("priority_after");

        // Idle and reserved select bits
        sel = 5'b00000;
        tick("idle");
        sel = 5'b00100;
        tick("reserved");

        // Selected port not valid: data/vc still forwarded
        sel = 5'b00010; ivalid_1 = 1'b0; idata_1 = 64'h0123_4567_89AB_CDEF; ivch_1 = 2'd1;
        tick("sel_not_valid");

        // Unselected port driven to X must not leak
        sel = 5'b00001; idata_0 = 64'h1111_2222_3333_4444; ivalid_0 = 1'b1; ivch_0 = 2'd2;
        idata_1 = 'x; ivalid_1 = 1'bx; ivch_1 = 'x;
        tick("x_unselected");

        // Mid-packet switch 01 -> 10 and reset mid-packet
        ivalid_0 = 1'b1; ivalid_1 = 1'b1; ivch_1 = 2'd3;
        for (int i = 0; i < 6; i++) begin
            sel = (i < 3) ? 5'b00001 : 5'b00010;
            idata_0 = rnd64(); idata_1 = rnd64();
            tick("switch");
        end
        rst = 1'b1;
        tick("mid_reset");
        rst = 1'b0;
        tick("post_reset");

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 31) == 0);
            sel = 5'($urandom);
            if ($urandom_range(0, 1) == 1) sel[4:2] = 3'b000;
            idata_0 = rnd64(); ivalid_0 = 1'($urandom); ivch_0 = 2'($urandom);
            idata_1 = rnd64(); ivalid_1 = 1'($urandom); ivch_1 = 2'($urandom);
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
